pipe_stall_ctrl: RTL

- Consumer end of the load-use stall signal: owns the PC register and the IF/ID and ID/EX pipeline registers, and turns the hazard unit's stall request into front-end freeze plus bubble injection.
- Sits between instruction memory, the ID stage decoder and the EX stage.
- Also applies branch flush and keeps saturating stall/flush statistics.

---
 rtl/pipe_stall_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// Front-end pipeline control: owns the PC, IF/ID and ID/EX registers.
// Converts a load-use stall request into a fetch freeze plus an ID/EX bubble,
// applies branch-flush redirects, and keeps saturating stall/flush counters.
// Every output comes straight from a register.
module pipe_stall_ctrl #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned REG_W   = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_in,
    input  logic               flush_in,
    input  logic [PC_W-1:0]    branch_target,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               id_regwrite,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid,
    output logic               idex_valid,
    output logic [REG_W-1:0]   idex_rd,
    output logic               idex_regwrite,
    output logic               stall_active,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic               idex_valid_q, idex_valid_d;
    logic [REG_W-1:0]   idex_rd_q, idex_rd_d;
    logic               idex_regwrite_q, idex_regwrite_d;
    logic               stall_active_q, stall_active_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               eff_stall;

    // A stall only matters when IF/ID holds a real instruction; flush wins.
    assign eff_stall = stall_in & ifid_valid_q & ~flush_in;

    // Next-state selection: flush, then stall, then normal advance.
    always_comb begin
        pc_d            = pc_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_valid_d    = ifid_valid_q;
        idex_valid_d    = 1'b0;
        idex_rd_d       = '0;
        idex_regwrite_d = 1'b0;
        stall_active_d  = eff_stall;
        stall_cnt_d     = stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;

        if (flush_in) begin
            pc_d         = branch_target;
            ifid_instr_d = '0;
            ifid_pc_d    = '0;
            ifid_valid_d = 1'b0;
            if (flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end else if (eff_stall) begin
            // PC and IF/ID hold; ID/EX takes the bubble from the defaults.
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else begin
            pc_d            = pc_q + PC_W'(1);
            ifid_instr_d    = instr_in;
            ifid_pc_d       = pc_q;
            ifid_valid_d    = 1'b1;
            idex_valid_d    = ifid_valid_q;
            idex_rd_d       = id_rd;
            idex_regwrite_d = id_regwrite & ifid_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= '0;
            ifid_instr_q    <= '0;
            ifid_pc_q       <= '0;
            ifid_valid_q    <= 1'b0;
            idex_valid_q    <= 1'b0;
            idex_rd_q       <= '0;
            idex_regwrite_q <= 1'b0;
            stall_active_q  <= 1'b0;
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
        end else begin
            pc_q            <= pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_valid_q    <= ifid_valid_d;
            idex_valid_q    <= idex_valid_d;
            idex_rd_q       <= idex_rd_d;
            idex_regwrite_q <= idex_regwrite_d;
            stall_active_q  <= stall_active_d;
            stall_cnt_q     <= stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign pc_out        = pc_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_valid    = ifid_valid_q;
    assign idex_valid    = idex_valid_q;
    assign idex_rd       = idex_rd_q;
    assign idex_regwrite = idex_regwrite_q;
    assign stall_active  = stall_active_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule
